icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SETS, default 16, number of direct-mapped one-word frames; power of two, 2..256.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath instruction byte address, word aligned.
REQ-006 ihit  output  1  requested word valid on imemload this cycle.
REQ-007 imemload  output  32  instruction word returned to datapath.
REQ-008 iREN  output  1  memory-side read request.
REQ-009 iaddr  output  32  memory-side read address.
REQ-010 iwait  input  1  memory busy; read data not yet valid.
REQ-011 iload  input  32  memory-side read data, valid when iREN=1 and iwait=0.
REQ-012 hit_count, miss_count  output  32 each  statistics counters (see Configuration).

Function
REQ-013 Address split: [1:0] ignored, index = [2+log2(SETS)-1:2], tag = remaining upper bits.
REQ-014 Per frame: valid bit, tag, 32-bit data.
REQ-015 States: IDLE, FETCH.
REQ-016 IDLE, imemREN=1, frame valid and tag match -> ihit=1, imemload=frame data same cycle (zero-cycle hit), stay IDLE.
REQ-017 IDLE, imemREN=1, miss -> ihit=0, latch imemaddr as miss address, go to FETCH next edge.
REQ-018 IDLE, imemREN=0 -> ihit=0, iREN=0, no state change.
REQ-019 FETCH: iREN=1, iaddr=latched miss address, ihit=0.
REQ-020 FETCH, iwait=1 -> remain FETCH, no frame update.
REQ-021 FETCH, iwait=0 -> write iload, tag, valid=1 into indexed frame; return to IDLE; lookup re-evaluated next cycle (miss penalty = memory latency + 1 cycle).
REQ-022 Change of imemaddr or imemREN during FETCH (branch redirect) shall not abort fill; latched address completes, new address evaluated in IDLE.
REQ-023 Fill replaces frame unconditionally (direct-mapped, no dirty state; read-only cache).
REQ-024 iaddr = latched miss address in FETCH, imemaddr in IDLE; iREN=0 outside FETCH.
REQ-025 imemload = 0 whenever ihit=0.
REQ-026 ihit never asserted in FETCH, including the fill-completion cycle.

Reset
REQ-027 RST=1: all valid bits cleared, state IDLE, miss address 0, counters 0; ihit=0, iREN=0, iaddr=0 asserted for reset cycle regardless of other inputs.
REQ-028 RST during FETCH abandons fill; no frame written that cycle even if iwait=0.
REQ-029 Tag/data arrays need no reset; valid bits gate all use.

Configuration
REQ-030 Macro ICACHE_STATS_EN defined: hit_count increments once per IDLE cycle with ihit=1; miss_count increments once per IDLE->FETCH transition; both saturate at 32'hFFFFFFFF.
REQ-031 ICACHE_STATS_EN undefined: counter logic absent, hit_count and miss_count tied to 0; all other behaviour identical.

Verification
REQ-032 Reset then imemREN=1, imemaddr=0x00000000 -> ihit=0, next cycle iREN=1 iaddr=0x0; memory iwait=1 for 2 cycles then iload=0x3C010001 -> following cycle ihit=1 imemload=0x3C010001.
REQ-033 Repeat read 0x00000000 after fill -> ihit=1 same cycle, iREN=0, hit_count=1 (stats enabled).
REQ-034 SETS=16: fill 0x00000004, then read 0x00000044 (same index 1, different tag) -> miss, refill, later read 0x00000004 -> miss again.
REQ-035 In FETCH for 0x00000008, change imemaddr to 0x00000100 -> iaddr stays 0x00000008 until iwait=0; then FETCH for 0x00000100 begins; miss_count=2.
REQ-036 RST asserted in FETCH coincident with iwait=0 -> no frame written; subsequent read of same address misses.
REQ-037 Build without ICACHE_STATS_EN, run REQ-032/033 -> identical ihit/iREN timing, hit_count=miss_count=0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t          state, next;
   logic [SETS-1:0] valid;
   logic [TW-1:0]   tags [SETS];
   logic [31:0]     data [SETS];
   logic [31:0]     miss_addr;

   logic [IW-1:0]   idx, fidx;
   logic [TW-1:0]   tag, ftag;
   logic            match;
   logic            fill;
   logic            miss_start;

   assign idx   = imemaddr[IW+1:2];
   assign tag   = imemaddr[31:IW+2];
   assign fidx  = miss_addr[IW+1:2];
   assign ftag  = miss_addr[31:IW+2];
   assign match = valid[idx] && (tags[idx] == tag);

   always_comb begin
      next       = state;
      ihit       = 1'b0;
      imemload   = '0;
      iREN       = 1'b0;
      iaddr      = imemaddr;
      fill       = 1'b0;
      miss_start = 1'b0;
      if (RST) begin
         iaddr = '0;
      end else begin
         case (state)
            IDLE: begin
               if (imemREN) begin
                  if (match) begin
                     ihit     = 1'b1;
                     imemload = data[idx];
                  end else begin
                     miss_start = 1'b1;
                     next       = FETCH;
                  end
               end
            end
            FETCH: begin
               iREN  = 1'b1;
               iaddr = miss_addr;
               if (!iwait) begin
                  fill = 1'b1;
                  next = IDLE;
               end
            end
            default: next = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         valid     <= '0;
         miss_addr <= '0;
      end else begin
         state <= next;
         if (miss_start)
            miss_addr <= imemaddr;
         if (fill)
            valid[fidx] <= 1'b1;
      end
   end

   // Tag and data arrays stay unreset; the valid bits gate every use.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tags[fidx] <= ftag;
         data[fidx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (miss_start && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected fetches and hits,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_icache;

   logic        CLK;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   icache #(.SETS(16)) dut (
      .CLK(CLK),
      .RST(RST),
      .imemREN(imemREN),
      .imemaddr(imemaddr),
      .ihit(ihit),
      .imemload(imemload),
      .iREN(iREN),
      .iaddr(iaddr),
      .iwait(iwait),
      .iload(iload),
      .hit_count(hit_count),
      .miss_count(miss_count)
   );

   typedef struct {
      bit          fill;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   exp_hits = 0;
   int   exp_miss = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endfunction

   // Monitor: every response the DUT presents must match the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (ihit) begin
               if (q.size() == 0 || q[0].fill) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_hit: got ihit=1 addr %h, required no hit", imemaddr);
               end else begin
                  e = q.pop_front();
                  chk("hit_data", imemload, e.data);
                  chk("hit_iren", {31'b0, iREN}, 32'd0);
               end
            end else begin
               chk("noh_load_zero", imemload, 32'd0);
            end
            if (iREN) begin
               if (q.size() == 0 || !q[0].fill) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_fetch: got iREN=1 iaddr %h, required no fetch", iaddr);
               end else begin
                  chk("fetch_addr", iaddr, q[0].addr);
                  if (!iwait)
                     void'(q.pop_front());
               end
            end
         end
      end
   end

   task automatic drain();
      chk("drain", q.size(), 32'd0);
      q.delete();
   endtask

   task automatic chk_stats(string tag);
`ifdef ICACHE_STATS_EN
      chk({tag, "_hit_count"}, hit_count, exp_hits);
      chk({tag, "_miss_count"}, miss_count, exp_miss);
`else
      chk({tag, "_hit_count"}, hit_count, 32'd0);
      chk({tag, "_miss_count"}, miss_count, 32'd0);
`endif
   endtask

   task automatic reset_dut();
      RST      = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      iwait    = 1'b0;
      iload    = 32'hFFFF_FFFF;
      @(negedge CLK);
      chk("rst_ihit", {31'b0, ihit}, 32'd0);
      chk("rst_iren", {31'b0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      @(posedge CLK);
      #1;
      RST     = 1'b0;
      imemREN = 1'b0;
      iwait   = 1'b1;
      iload   = '0;
      q.delete();
      exp_hits = 0;
      exp_miss = 0;
      chk_stats("rst");
   endtask

   task automatic access(input logic [31:0] a, input bit hit,
                         input logic [31:0] d, input int lat);
      imemaddr = a;
      imemREN  = 1'b1;
      if (hit) begin
         q.push_back('{1'b0, a, d});
         exp_hits++;
         @(posedge CLK);
         #1;
      end else begin
         q.push_back('{1'b1, a, d});
         q.push_back('{1'b0, a, d});
         exp_miss++;
         exp_hits++;
         iwait = 1'b1;
         @(posedge CLK);
         #1;
         repeat (lat) begin
            @(posedge CLK);
            #1;
         end
         iwait = 1'b0;
         iload = d;
         @(posedge CLK);
         #1;
         iwait = 1'b1;
         iload = '0;
         @(posedge CLK);
         #1;
      end
      imemREN = 1'b0;
      drain();
   endtask

   initial begin
      RST      = 1'b1;
      imemREN  = 1'b0;
      imemaddr = '0;
      iwait    = 1'b1;
      iload    = '0;
      @(posedge CLK);
      #1;
      reset_dut();

      // Cold miss with two wait cycles, then a repeat hit.
      access(32'h0000_0000, 1'b0, 32'h3C01_0001, 2);
      chk_stats("cold");
      access(32'h0000_0000, 1'b1, 32'h3C01_0001, 0);
      chk_stats("rehit");

      // Conflict on index 1, then highest index with an all-ones tag.
      access(32'h0000_0004, 1'b0, 32'h1111_0004, 0);
      access(32'h0000_0044, 1'b0, 32'h2222_0044, 1);
      access(32'h0000_0004, 1'b0, 32'h1111_0004, 3);
      access(32'h0000_0000, 1'b1, 32'h3C01_0001, 0);
      access(32'hFFFF_FFFC, 1'b0, 32'hCAFE_F00D, 1);
      access(32'hFFFF_FFFC, 1'b1, 32'hCAFE_F00D, 0);
      chk_stats("conflict");

      // Redirect during a fill: latched address must complete first.
      reset_dut();
      q.push_back('{1'b1, 32'h0000_0008, 32'hAAAA_0008});
      q.push_back('{1'b1, 32'h0000_0100, 32'hBBBB_0100});
      q.push_back('{1'b0, 32'h0000_0100, 32'hBBBB_0100});
      exp_miss += 2;
      exp_hits += 1;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0008;
      iwait    = 1'b1;
      @(posedge CLK);
      #1;
      imemaddr = 32'h0000_0100;
      repeat (2) begin
         @(posedge CLK);
         #1;
      end
      iwait = 1'b0;
      iload = 32'hAAAA_0008;
      @(posedge CLK);
      #1;
      iwait = 1'b1;
      iload = '0;
      @(posedge CLK);
      #1;
      iwait = 1'b0;
      iload = 32'hBBBB_0100;
      @(posedge CLK);
      #1;
      iwait = 1'b1;
      iload = '0;
      @(posedge CLK);
      #1;
      imemREN = 1'b0;
      drain();
      chk_stats("redirect");
      access(32'h0000_0008, 1'b1, 32'hAAAA_0008, 0);
      access(32'h0000_0100, 1'b1, 32'hBBBB_0100, 0);

      // Reset landing on the fill-completion cycle must not write the frame.
      q.push_back('{1'b1, 32'h0000_000C, 32'hDEAD_BEEF});
      imemREN  = 1'b1;
      imemaddr = 32'h0000_000C;
      iwait    = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RST   = 1'b1;
      iwait = 1'b0;
      iload = 32'hDEAD_BEEF;
      @(negedge CLK);
      chk("rstfill_iren", {31'b0, iREN}, 32'd0);
      chk("rstfill_ihit", {31'b0, ihit}, 32'd0);
      chk("rstfill_iaddr", iaddr, 32'd0);
      @(posedge CLK);
      #1;
      RST     = 1'b0;
      imemREN = 1'b0;
      iwait   = 1'b1;
      iload   = '0;
      q.delete();
      exp_hits = 0;
      exp_miss = 0;
      access(32'h0000_000C, 1'b0, 32'h0C0C_0C0C, 1);
      chk_stats("rstfill");

      @(posedge CLK);
      #1;
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
